// File: rtl/wdu_pkg.sv
// Shared types, defaults and the weight reconstruction rule for the weight decode unit.
// Optional build macro WDU_ROUND_EN selects midpoint rounding for outlier weights.
package wdu_pkg;

   localparam int DEF_ROWS     = 8;
   localparam int DEF_ADDR_W   = 6;
   localparam int DEF_COMP_MAX = 3;
   localparam int ROW_W        = $clog2(DEF_ROWS);

   typedef enum logic {
      S_FILL,
      S_DRAIN
   } wdu_state_t;

   // Rebuild an 8-bit weight from a reduced entry and an optional compensation value.
   function automatic logic [7:0] wdu_recon(input logic [4:0] r,
                                            input logic       c_valid,
                                            input logic [2:0] c);
      logic [7:0] w;
      if (!r[4]) begin
         w = {{3{r[3]}}, r[3:0], 1'b0};
      end else if (c_valid) begin
`ifdef WDU_ROUND_EN
         w = {r[3:0], c, 1'b1};
`else
         w = {r[3:0], c, 1'b0};
`endif
      end else begin
`ifdef WDU_ROUND_EN
         w = {r[3:0], 4'b1000};
`else
         w = {r[3:0], 4'b0000};
`endif
      end
      return w;
   endfunction

endpackage

// File: rtl/wdu_column_decoder_comp_table.sv
// Direct-mapped compensation table: one 3-bit entry per row, bounded entry count,
// sticky overflow flag and a read port that forwards a same-cycle accepted write.
import wdu_pkg::*;

module wdu_column_decoder_comp_table #(
   parameter int ROWS     = DEF_ROWS,
   parameter int COMP_MAX = DEF_COMP_MAX
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_valid,
   input  logic [$clog2(ROWS)-1:0]  i_wr_row,
   input  logic [2:0]               i_wr_data,
   input  logic                     i_clear,
   input  logic [$clog2(ROWS)-1:0]  i_rd_row,
   output logic                     o_rd_valid,
   output logic [2:0]               o_rd_data,
   output logic                     o_overflow
);

   localparam int CNT_W = $clog2(COMP_MAX + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(COMP_MAX);

   logic [ROWS-1:0] r_valid;
   logic [2:0]      r_data [ROWS];
   logic [CNT_W-1:0] r_count;
   logic            r_overflow;
   logic            w_accept;
   logic            w_fwd;

   assign w_accept   = i_wr_valid && !i_clear && (r_valid[i_wr_row] || (r_count < MAX_CNT));
   assign w_fwd      = w_accept && (i_wr_row == i_rd_row);
   assign o_rd_valid = r_valid[i_rd_row] | w_fwd;
   assign o_rd_data  = w_fwd ? i_wr_data : r_data[i_rd_row];
   assign o_overflow = r_overflow;

   // Rewriting a row already present never consumes a new slot; only new rows are bounded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < ROWS; i++) r_data[i] <= '0;
      end else if (i_clear) begin
         r_valid <= '0;
         r_count <= '0;
      end else if (i_wr_valid) begin
         if (r_valid[i_wr_row]) begin
            r_data[i_wr_row] <= i_wr_data;
         end else if (r_count < MAX_CNT) begin
            r_valid[i_wr_row] <= 1'b1;
            r_data[i_wr_row]  <= i_wr_data;
            r_count           <= r_count + CNT_W'(1);
         end else begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wdu_column_decoder.sv
// Weight decode unit: collects one column of reduced weights, then drains the
// reconstructed 8-bit weights in row order. Build macro: WDU_ROUND_EN (see wdu_pkg).
import wdu_pkg::*;

module wdu_column_decoder #(
   parameter int ROWS     = DEF_ROWS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int COMP_MAX = DEF_COMP_MAX
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rw_in_valid,
   output logic                     rw_in_ready,
   input  logic [4:0]               rw_in_data,
   input  logic [ADDR_W-1:0]        rw_in_addr,
   input  logic                     comp_in_valid,
   output logic                     comp_in_ready,
   input  logic [$clog2(ROWS)-1:0]  comp_in_row,
   input  logic [2:0]               comp_in_weight,
   output logic                     w_out_valid,
   input  logic                     w_out_ready,
   output logic [7:0]               w_out_data,
   output logic [ADDR_W-1:0]        w_out_addr,
   output logic                     w_out_col_last,
   output logic                     comp_overflow,
   output logic                     order_err
);

   localparam int ROW_BITS = $clog2(ROWS);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

   wdu_state_t          r_state;
   wdu_state_t          w_nextState;
   logic                w_inReady;
   logic [4:0]          r_bufData [ROWS];
   logic [ADDR_W-1:0]   r_bufAddr [ROWS];
   logic [ROW_BITS-1:0] r_expRow;
   logic                r_orderErr;
   logic [ROW_BITS-1:0] r_drainRow;
   logic                r_outValid;
   logic [7:0]          r_outData;
   logic [ADDR_W-1:0]   r_outAddr;
   logic                r_outLast;

   logic                w_rwFire;
   logic                w_compFire;
   logic                w_outFire;
   logic [ROW_BITS-1:0] w_beatRow;
   logic [ROW_BITS-1:0] w_loadRow;
   logic                w_load;
   logic                w_drainDone;
   logic                w_compValid;
   logic [2:0]          w_compData;

   assign w_beatRow   = rw_in_addr[ROW_BITS-1:0];
   assign w_rwFire    = rw_in_valid & w_inReady;
   assign w_compFire  = comp_in_valid & w_inReady;
   assign w_outFire   = r_outValid & w_out_ready;
   assign w_loadRow   = (r_state == S_FILL) ? '0 : r_drainRow + ROW_BITS'(1);
   assign w_load      = ((r_state == S_FILL) && w_rwFire && (w_beatRow == LAST_ROW)) ||
                        ((r_state == S_DRAIN) && w_outFire && (r_drainRow != LAST_ROW));
   assign w_drainDone = (r_state == S_DRAIN) && w_outFire && (r_drainRow == LAST_ROW);

   assign rw_in_ready    = w_inReady;
   assign comp_in_ready  = w_inReady;
   assign w_out_valid    = r_outValid;
   assign w_out_data     = r_outData;
   assign w_out_addr     = r_outAddr;
   assign w_out_col_last = r_outLast;
   assign order_err      = r_orderErr;

   wdu_column_decoder_comp_table #(
      .ROWS     (ROWS),
      .COMP_MAX (COMP_MAX)
   ) u_compTable (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_valid (w_compFire),
      .i_wr_row   (comp_in_row),
      .i_wr_data  (comp_in_weight),
      .i_clear    (w_drainDone),
      .i_rd_row   (w_loadRow),
      .o_rd_valid (w_compValid),
      .o_rd_data  (w_compData),
      .o_overflow (comp_overflow)
   );

   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      case (r_state)
         S_FILL: begin
            w_inReady = 1'b1;
            if (w_rwFire && (w_beatRow == LAST_ROW)) w_nextState = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drainDone) w_nextState = S_FILL;
         end
         default: w_nextState = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FILL;
      else        r_state <= w_nextState;
   end

   // Beats are stored at their own row even when out of order; the expected row just counts beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_expRow   <= '0;
         r_orderErr <= 1'b0;
         for (int i = 0; i < ROWS; i++) begin
            r_bufData[i] <= '0;
            r_bufAddr[i] <= '0;
         end
      end else if (w_rwFire) begin
         r_bufData[w_beatRow] <= rw_in_data;
         r_bufAddr[w_beatRow] <= rw_in_addr;
         r_expRow             <= r_expRow + ROW_BITS'(1);
         if (w_beatRow != r_expRow) r_orderErr <= 1'b1;
      end
   end

   // Output register loads the next row on column completion or on each handshake, else holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outAddr  <= '0;
         r_outLast  <= 1'b0;
         r_drainRow <= '0;
      end else if (w_load) begin
         r_outValid <= 1'b1;
         r_outData  <= wdu_recon(r_bufData[w_loadRow], w_compValid, w_compData);
         r_outAddr  <= r_bufAddr[w_loadRow];
         r_outLast  <= (w_loadRow == LAST_ROW);
         r_drainRow <= w_loadRow;
      end else if (w_drainDone) begin
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end
   end

endmodule
